// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
//   DEFAULT_XLEN / DEFAULT_AW : default data and address widths
//   reg_addr_t / xlen_t       : address and data types for the default geometry
//   is_zero_reg()             : true when an address is the hardwired zero register
package regfile_pkg;

  localparam int DEFAULT_XLEN     = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_AW       = $clog2(DEFAULT_NUM_REGS);
  // Widest address the helper accepts; callers zero-extend into it.
  localparam int ADDR_MAX_W       = 32;

  typedef logic [DEFAULT_AW-1:0]   reg_addr_t;
  typedef logic [DEFAULT_XLEN-1:0] xlen_t;

  // zero_en carries the ZERO_REG parameter so one helper serves both variants.
  function automatic logic is_zero_reg(input logic [ADDR_MAX_W-1:0] addr,
                                       input logic zero_en);
    return zero_en && (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for in-flight writebacks.
//   clk, reset_n          : clock, synchronous active-low reset
//   wr_en, wr_addr        : writeback clears the busy bit of wr_addr
//   issue_en, issue_addr  : issue sets the busy bit of issue_addr (wins over clear)
//   busy_vec              : registered scoreboard
//   busy_next             : scoreboard as it will be after this edge, used by
//                           the read ports so their busy view matches bypass
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [NUM_REGS-1:0] busy_next
);

  logic [NUM_REGS-1:0] busy_reg;
  logic                clear_ok;
  logic                set_ok;

  // The zero register is never marked, so its bit stays 0 from reset onward.
  assign clear_ok = wr_en    && !is_zero_reg(ADDR_MAX_W'(wr_addr),    ZERO_REG != 0);
  assign set_ok   = issue_en && !is_zero_reg(ADDR_MAX_W'(issue_addr), ZERO_REG != 0);

  // Clear first, then set: a same-cycle issue to the written register wins.
  always_comb begin
    busy_next = busy_reg;
    if (clear_ok) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      busy_next[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD registered read ports, one write port,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_rd_en / i_rd_addr       : per-port read request
//   o_rd_data / o_rd_busy     : per-port registered result (held when idle)
//   o_rd_valid                : high one cycle after an accepted read
//   i_wr_en/i_wr_addr/i_wr_data : writeback (also clears busy)
//   i_issue_en/i_issue_addr   : mark destination busy
//   o_busy_vec                : registered scoreboard
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_RD-1:0]            i_rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]    i_rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]  o_rd_data,
  output logic [NUM_RD-1:0]            o_rd_valid,
  output logic [NUM_RD-1:0]            o_rd_busy,
  input  logic                         i_wr_en,
  input  logic [AW-1:0]                i_wr_addr,
  input  logic [XLEN-1:0]              i_wr_data,
  input  logic                         i_issue_en,
  input  logic [AW-1:0]                i_issue_addr,
  output logic [NUM_REGS-1:0]          o_busy_vec
);

  logic [XLEN-1:0]     mem_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_zero;

  assign wr_zero = is_zero_reg(ADDR_MAX_W'(i_wr_addr), ZERO_REG != 0);

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (i_clk),
    .reset_n    (i_reset_n),
    .wr_en      (i_wr_en),
    .wr_addr    (i_wr_addr),
    .issue_en   (i_issue_en),
    .issue_addr (i_issue_addr),
    .busy_vec   (o_busy_vec),
    .busy_next  (busy_next)
  );

  // Storage is cleared by reset, so it maps to registers rather than RAM.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (i_wr_en && !wr_zero) begin
      mem_reg[i_wr_addr] <= i_wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic            rd_zero;
      logic            wr_hit;
      logic [XLEN-1:0] data_next;
      logic [XLEN-1:0] data_reg;
      logic            busy_reg;
      logic            valid_reg;

      assign rd_zero = is_zero_reg(ADDR_MAX_W'(i_rd_addr[gi]), ZERO_REG != 0);
      assign wr_hit  = i_wr_en && (i_wr_addr == i_rd_addr[gi]);

      // Zero register wins over bypass, bypass wins over stored data.
      always_comb begin
        data_next = mem_reg[i_rd_addr[gi]];
        if (wr_hit) begin
          data_next = i_wr_data;
        end
        if (rd_zero) begin
          data_next = '0;
        end
      end

      // busy_next already folds in the same-cycle write/issue, so the busy
      // flag agrees with the bypassed data.
      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          data_reg  <= '0;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= i_rd_en[gi];
          if (i_rd_en[gi]) begin
            data_reg <= data_next;
            busy_reg <= busy_next[i_rd_addr[gi]];
          end
        end
      end

      assign o_rd_data[gi]  = data_reg;
      assign o_rd_busy[gi]  = busy_reg;
      assign o_rd_valid[gi] = valid_reg;
    end
  endgenerate

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor to the core's single-write/dual-read register file. Provides NUM_RD registered read ports, one write port, same-cycle write-to-read bypass and a per-register busy scoreboard for in-flight writebacks. Sits between decode (reads, issue marking) and writeback (writes, busy clearing) in the integer pipeline.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy
AW, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset_n  in  1  synchronous active-low reset
i_rd_en  in  NUM_RD  per-port read enable
i_rd_addr  in  NUM_RD x AW  per-port read address
o_rd_data  out  NUM_RD x XLEN  per-port registered read data
o_rd_valid  out  NUM_RD  high one cycle after an accepted read
o_rd_busy  out  NUM_RD  scoreboard state of the register read, registered alongside o_rd_data
i_wr_en  in  1  write enable
i_wr_addr  in  AW  write address
i_wr_data  in  XLEN  write data
i_issue_en  in  1  mark destination register busy (instruction issued)
i_issue_addr  in  AW  destination register being issued
o_busy_vec  out  NUM_REGS  current scoreboard, bit n = register n busy

Behaviour:
- Reset (i_reset_n=0 at rising edge): all registers 0, busy_vec 0, o_rd_data 0, o_rd_valid 0, o_rd_busy 0. Overrides every concurrent read/write/issue; a reset mid-operation discards in-flight state.
- Read latency 1 cycle: i_rd_en[p] at edge k -> o_rd_data[p], o_rd_busy[p], o_rd_valid[p]=1 after edge k. Read ports are fully independent; the same address on several ports is legal.
- i_rd_en[p]=0: o_rd_valid[p]=0 next cycle; o_rd_data[p] and o_rd_busy[p] hold their previous values. Outputs are never high-impedance.
- Bypass: i_wr_en=1 with i_wr_addr==i_rd_addr[p] in the same cycle -> o_rd_data[p]=i_wr_data (new value) and o_rd_busy[p]=0, unless that busy bit is re-set by a same-cycle issue (rule below).
- ZERO_REG=1: writes and issues to address 0 are ignored; reads of address 0 return 0 with busy 0, including under bypass.
- Write: i_wr_en=1 updates register i_wr_addr at the edge and clears its busy bit.
- Issue: i_issue_en=1 sets busy bit i_issue_addr at the edge.
- Simultaneous write and issue to the same address: data is written and busy ends set (the new issue wins). To different addresses: both take effect.
- o_busy_vec reflects the scoreboard after the edge (registered, no combinational path from inputs).
- o_rd_busy[p] is sampled from the scoreboard before the edge, with the same-cycle write/issue rules applied. Bypass and o_rd_busy must agree: clear is seen, set is seen.
- Address width: addresses >= NUM_REGS cannot occur (power-of-two depth). No wrap logic is needed.

Decomposition:
- Package regfile_pkg: XLEN default constant, typedef reg_addr_t (logic [AW-1:0]) for the default depth, typedef xlen_t (logic [XLEN-1:0]), and function is_zero_reg(addr) used by both modules.
- One sub-module is natural: regfile_scoreboard (NUM_REGS, ZERO_REG). It holds busy_vec and the set/clear priority, and exports busy_vec plus a next-state view for the read ports.
- The storage array and read/bypass muxes stay in the top.

Test Plan:
- Reset then read all registers on ports 0/1 -> o_rd_data=0, o_rd_valid=1 one cycle after each read, o_busy_vec=0.
- Write 0xDEADBEEF to r5, next cycle read r5 on both ports -> both o_rd_data=0xDEADBEEF one cycle later. Disable port 1 the following cycle -> o_rd_valid[1]=0 and o_rd_data[1] still 0xDEADBEEF.
- Same cycle: write r7=0x12345678 and read r7 on port 0, with r7 previously 0x1 -> o_rd_data[0]=0x12345678.
- Write 0xFFFFFFFF to r0 and issue r0, then read r0 -> data 0, o_rd_busy=0, o_busy_vec[0]=0.
- Issue r3 -> o_busy_vec[3]=1 and read r3 gives o_rd_busy=1. Write r3 and issue r3 in the same cycle -> busy stays 1. Write r3 alone -> busy 0.
- Fill r1..r4, issue r2, then hold i_reset_n=0 for one edge while a write r4 and a read r1 are active -> all registers 0, o_busy_vec=0, o_rd_valid=0, and the write is lost.
